// File: rtl/dpmem_port_scheduler.sv
// Four-requester round-robin scheduler driving the two ports of dual_port_memory.
// Each port runs a small FSM that sequences writes (one cycle) and the memory's
// two-phase read (fetch, then drive). Same-cycle same-address hazards between
// the two winners are resolved by granting only the earlier one in scan order.
module dpmem_port_scheduler #(
  parameter int data_size = 8,
  parameter int address   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               req_valid,
  input  logic [3:0]               req_we,
  input  logic [4*address-1:0]     req_addr,
  input  logic [4*data_size-1:0]   req_wdata,
  output logic [3:0]               req_ready,
  output logic                     rsp0_valid,
  output logic [1:0]               rsp0_id,
  output logic [data_size-1:0]     rsp0_data,
  output logic                     rsp1_valid,
  output logic [1:0]               rsp1_id,
  output logic [data_size-1:0]     rsp1_data,
  output logic                     cs0,
  output logic                     write_en0,
  output logic                     read_en0,
  output logic                     cs1,
  output logic                     write_en1,
  output logic                     read_en1,
  output logic [address-1:0]       address_in0,
  output logic [address-1:0]       address_in1,
  inout  wire  [data_size-1:0]     data_io0,
  inout  wire  [data_size-1:0]     data_io1
);

  typedef enum logic [1:0] {IDLE, WRITE, RFETCH, RDRIVE} state_t;

  logic [1:0]                 rr_reg, rr_next;
  logic [1:0]                 avail;
  logic [1:0]                 grant_valid;
  logic [1:0][1:0]            grant_idx;
  logic                       first_found, second_found, hazard;
  logic [1:0]                 first_idx, second_idx, scan_idx;

  logic [1:0]                 port_cs, port_we, port_re, port_drive;
  logic [1:0][address-1:0]    port_addr;
  logic [1:0][data_size-1:0]  port_wdata;
  logic [1:0][data_size-1:0]  bus_in;
  logic [1:0]                 rsp_valid;
  logic [1:0][1:0]            rsp_id;
  logic [1:0][data_size-1:0]  rsp_data;

  // Find the first two valid requesters scanning from the round-robin pointer
  always_comb begin
    first_found  = 1'b0;
    second_found = 1'b0;
    first_idx    = '0;
    second_idx   = '0;
    scan_idx     = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = rr_reg + 2'(k);
      if (req_valid[scan_idx]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_idx   = scan_idx;
        end else if (!second_found) begin
          second_found = 1'b1;
          second_idx   = scan_idx;
        end
      end
    end
  end

  // Map winners onto available ports, suppress the later winner on an address hazard
  always_comb begin
    grant_valid = '0;
    grant_idx   = '0;
    req_ready   = '0;
    rr_next     = rr_reg;
    hazard      = (req_addr[first_idx*address +: address] == req_addr[second_idx*address +: address])
                  && (req_we[first_idx] || req_we[second_idx]);
    if (rst_n && first_found) begin
      if (avail[0]) begin
        grant_valid[0] = 1'b1;
        grant_idx[0]   = first_idx;
        if (second_found && avail[1] && !hazard) begin
          grant_valid[1] = 1'b1;
          grant_idx[1]   = second_idx;
        end
      end else if (avail[1]) begin
        grant_valid[1] = 1'b1;
        grant_idx[1]   = first_idx;
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (grant_valid[p]) req_ready[grant_idx[p]] = 1'b1;
    end
    // Port 1 always holds the later-in-scan grant when both ports are granted
    if (grant_valid[1])      rr_next = grant_idx[1] + 2'd1;
    else if (grant_valid[0]) rr_next = grant_idx[0] + 2'd1;
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_reg <= '0;
    else        rr_reg <= rr_next;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    state_t                state_reg, state_next;
    logic [address-1:0]    addr_reg;
    logic [data_size-1:0]  wdata_reg;
    logic [1:0]            id_reg;
    logic                  rsp_valid_reg;
    logic [1:0]            rsp_id_reg;
    logic [data_size-1:0]  rsp_data_reg;
    logic                  cs_p, we_p, re_p;

    // Next state and memory-port controls decoded from the current state
    always_comb begin
      state_next = IDLE;
      cs_p       = 1'b0;
      we_p       = 1'b0;
      re_p       = 1'b0;
      case (state_reg)
        WRITE:  begin cs_p = 1'b1; we_p = 1'b1; end
        RFETCH: begin cs_p = 1'b1; end
        RDRIVE: begin cs_p = 1'b1; re_p = 1'b1; end
        default: ;
      endcase
      if (state_reg == RFETCH)  state_next = RDRIVE;
      else if (grant_valid[gi]) state_next = req_we[grant_idx[gi]] ? WRITE : RFETCH;
    end

    // State, latched request fields and read-response capture
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg     <= IDLE;
        addr_reg      <= '0;
        wdata_reg     <= '0;
        id_reg        <= '0;
        rsp_valid_reg <= 1'b0;
        rsp_id_reg    <= '0;
        rsp_data_reg  <= '0;
      end else begin
        state_reg     <= state_next;
        rsp_valid_reg <= (state_reg == RDRIVE);
        if (grant_valid[gi]) begin
          addr_reg  <= req_addr[grant_idx[gi]*address +: address];
          wdata_reg <= req_wdata[grant_idx[gi]*data_size +: data_size];
          id_reg    <= grant_idx[gi];
        end
        if (state_reg == RDRIVE) begin
          rsp_id_reg   <= id_reg;
          rsp_data_reg <= bus_in[gi];
        end
      end
    end

    assign avail[gi]      = (state_reg != RFETCH);
    assign port_cs[gi]    = cs_p;
    assign port_we[gi]    = we_p;
    assign port_re[gi]    = re_p;
    assign port_drive[gi] = (state_reg == WRITE);
    assign port_addr[gi]  = addr_reg;
    assign port_wdata[gi] = wdata_reg;
    assign rsp_valid[gi]  = rsp_valid_reg;
    assign rsp_id[gi]     = rsp_id_reg;
    assign rsp_data[gi]   = rsp_data_reg;
  end

  assign bus_in[0] = data_io0;
  assign bus_in[1] = data_io1;
  // The bus is driven only while writing; the memory owns it during RDRIVE
  assign data_io0 = port_drive[0] ? port_wdata[0] : 'z;
  assign data_io1 = port_drive[1] ? port_wdata[1] : 'z;

  assign cs0         = port_cs[0];
  assign write_en0   = port_we[0];
  assign read_en0    = port_re[0];
  assign cs1         = port_cs[1];
  assign write_en1   = port_we[1];
  assign read_en1    = port_re[1];
  assign address_in0 = port_addr[0];
  assign address_in1 = port_addr[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp0_id     = rsp_id[0];
  assign rsp0_data   = rsp_data[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp1_id     = rsp_id[1];
  assign rsp1_data   = rsp_data[1];

endmodule

// File: tb/tb_dpmem_port_scheduler.sv
// Bench for dpmem_port_scheduler: behavioural dual-port memory plus a
// transaction-level reference model (scan list, port busy flags, reference
// memory, expected per-cycle port activity and responses).
module tb_dpmem_port_scheduler;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      req_valid = '0, req_we = '0, req_ready;
  logic [4*AW-1:0] req_addr = '0;
  logic [4*DW-1:0] req_wdata = '0;
  logic            rsp0_valid, rsp1_valid;
  logic [1:0]      rsp0_id, rsp1_id;
  logic [DW-1:0]   rsp0_data, rsp1_data;
  logic            cs0, write_en0, read_en0, cs1, write_en1, read_en1;
  logic [AW-1:0]   address_in0, address_in1;
  wire  [DW-1:0]   data_io0, data_io1;

  dpmem_port_scheduler #(.data_size(DW), .address(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp0_valid(rsp0_valid), .rsp0_id(rsp0_id), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_id(rsp1_id), .rsp1_data(rsp1_data),
    .cs0(cs0), .write_en0(write_en0), .read_en0(read_en0),
    .cs1(cs1), .write_en1(write_en1), .read_en1(read_en1),
    .address_in0(address_in0), .address_in1(address_in1),
    .data_io0(data_io0), .data_io1(data_io1)
  );

  // Behavioural dual_port_memory: write on cs&we, latch on fetch, drive on re
  logic [DW-1:0] mem [16];
  logic [DW-1:0] lat0 = '0, lat1 = '0;
  always @(posedge clk) begin
    if (cs0 && write_en0) mem[address_in0] <= data_io0;
    if (cs0 && !write_en0 && !read_en0) lat0 <= mem[address_in0];
    if (cs1 && write_en1) mem[address_in1] <= data_io1;
    if (cs1 && !write_en1 && !read_en1) lat1 <= mem[address_in1];
  end
  assign data_io0 = (cs0 && read_en0) ? lat0 : 'z;
  assign data_io1 = (cs1 && read_en1) ? lat1 : 'z;

  // Reference model state
  int            n_tests = 0, n_fail = 0, cyc = 0;
  logic [DW-1:0] ref_mem [16];
  int            rr_m = 0;
  logic [1:0]    av_m = 2'b11;
  logic          exp_rv   [2][8];
  logic [1:0]    exp_rid  [2][8];
  logic [DW-1:0] exp_rd   [2][8];
  logic [2:0]    exp_ctl  [2][8];   // {cs, we, re}
  logic [AW-1:0] exp_addr [2][8];
  int            gcnt [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 8; s++) begin
        exp_rv[p][s] = 1'b0; exp_rid[p][s] = '0; exp_rd[p][s] = '0;
        exp_ctl[p][s] = '0; exp_addr[p][s] = '0;
      end
    rr_m = 0;
    av_m = 2'b11;
  endtask

  // One arbitration cycle: check what is due now, drive inputs, predict grants
  task automatic step(input logic [3:0] v, input logic [3:0] we,
                      input logic [15:0] a, input logic [31:0] wd);
    int         order[$];
    int         pidx[2];
    logic [1:0] pg;
    logic [3:0] exp_ready;
    logic [1:0] next_av;
    int         slot, last, i;
    logic [2:0] got_ctl;
    logic [AW-1:0] ad;
    @(negedge clk);
    slot = cyc % 8;
    for (int p = 0; p < 2; p++) begin
      got_ctl = (p == 0) ? {cs0, write_en0, read_en0} : {cs1, write_en1, read_en1};
      check($sformatf("ctl%0d", p), 32'(got_ctl), 32'(exp_ctl[p][slot]));
      if (exp_ctl[p][slot] != 3'b000)
        check($sformatf("addr%0d", p), 32'((p == 0) ? address_in0 : address_in1), 32'(exp_addr[p][slot]));
      check($sformatf("rsp%0d_valid", p), 32'((p == 0) ? rsp0_valid : rsp1_valid), 32'(exp_rv[p][slot]));
      if (exp_rv[p][slot]) begin
        check($sformatf("rsp%0d_id", p), 32'((p == 0) ? rsp0_id : rsp1_id), 32'(exp_rid[p][slot]));
        check($sformatf("rsp%0d_data", p), 32'((p == 0) ? rsp0_data : rsp1_data), 32'(exp_rd[p][slot]));
      end
      exp_rv[p][slot] = 1'b0; exp_ctl[p][slot] = '0;
    end
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
    #1;
    for (int k = 0; k < 4; k++)
      if (v[(rr_m + k) % 4]) order.push_back((rr_m + k) % 4);
    pg = '0; pidx[0] = 0; pidx[1] = 0;
    if (order.size() > 0) begin
      if (av_m[0]) begin
        pg[0] = 1'b1; pidx[0] = order[0];
        if (order.size() > 1 && av_m[1] &&
            !((a[order[0]*4 +: 4] == a[order[1]*4 +: 4]) && (we[order[0]] || we[order[1]]))) begin
          pg[1] = 1'b1; pidx[1] = order[1];
        end
      end else if (av_m[1]) begin
        pg[1] = 1'b1; pidx[1] = order[0];
      end
    end
    exp_ready = '0;
    last = -1;
    for (int p = 0; p < 2; p++)
      if (pg[p]) begin exp_ready[pidx[p]] = 1'b1; last = pidx[p]; end
    if (last >= 0) rr_m = (last + 1) % 4;
    check("ready", 32'(req_ready), 32'(exp_ready));
    for (int r = 0; r < 4; r++) if (req_ready[r] && v[r]) gcnt[r]++;
    next_av = 2'b11;
    for (int p = 0; p < 2; p++)
      if (pg[p]) begin
        i = pidx[p];
        ad = a[i*4 +: 4];
        exp_addr[p][(cyc+1)%8] = ad;
        if (we[i]) begin
          exp_ctl[p][(cyc+1)%8] = 3'b110;
          $display("[TB] cyc %0d req%0d write addr %0h data %0h on port%0d", cyc, i, ad, wd[i*8 +: 8], p);
        end else begin
          exp_ctl[p][(cyc+1)%8]  = 3'b100;
          exp_ctl[p][(cyc+2)%8]  = 3'b101;
          exp_addr[p][(cyc+2)%8] = ad;
          exp_rv[p][(cyc+3)%8]   = 1'b1;
          exp_rid[p][(cyc+3)%8]  = 2'(i);
          exp_rd[p][(cyc+3)%8]   = ref_mem[ad];
          next_av[p] = 1'b0;
          $display("[TB] cyc %0d req%0d read addr %0h expect %0h on port%0d", cyc, i, ad, ref_mem[ad], p);
        end
      end
    for (int p = 0; p < 2; p++)
      if (pg[p] && we[pidx[p]]) ref_mem[a[pidx[p]*4 +: 4]] = wd[pidx[p]*8 +: 8];
    av_m = next_av;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'h0, 4'h0, 16'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 4'hF; req_we = 4'h0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_ctl", 32'({cs0, write_en0, read_en0, cs1, write_en1, read_en1}), 32'h0);
    check("rst_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_id, rsp1_id, rsp0_data, rsp1_data}), 32'h0);
    @(negedge clk);
    check("rst_addr", 32'({address_in0, address_in1}), 32'h0);
    req_valid = 4'h0;
    rst_n = 1'b1;
    clear_model();
  endtask

  int acc;

  initial begin
    for (int k = 0; k < 16; k++) begin mem[k] = '0; ref_mem[k] = '0; end
    for (int r = 0; r < 4; r++) gcnt[r] = 0;
    clear_model();
    do_reset();

    // Single write then read on requester 0
    step(4'b0001, 4'b0001, 16'h0003, 32'h0000_00A5);
    step(4'b0001, 4'b0000, 16'h0003, 32'h0);
    idle(3);
    check("wr_rd_valid", 32'(rsp0_valid), 32'h1);
    check("wr_rd_data", 32'(rsp0_data), 32'hA5);

    // Dual issue from requesters 1 and 2
    step(4'b0110, 4'b0110, 16'h0210, 32'h0022_1100);
    check("dual_ready", 32'(req_ready), 32'h6);
    step(4'b0110, 4'b0000, 16'h0210, 32'h0);
    idle(3);
    check("dual_rd0", 32'(rsp0_data), 32'h11);
    check("dual_rd1", 32'(rsp1_data), 32'h22);

    // Same-address hazard with rr at 0
    do_reset();
    step(4'b0011, 4'b0001, 16'h0055, 32'h0000_005A);
    check("haz_ready", 32'(req_ready), 32'h1);
    step(4'b0010, 4'b0000, 16'h0050, 32'h0);
    check("haz_retry", 32'(req_ready), 32'h2);
    idle(3);
    check("haz_data", 32'(rsp0_data), 32'h5A);

    // Fairness under continuous reads from everyone
    for (int r = 0; r < 4; r++) gcnt[r] = 0;
    for (int k = 0; k < 32; k++) step(4'hF, 4'h0, 16'($urandom), 32'h0);
    idle(3);
    for (int r = 0; r < 4; r++) check($sformatf("fair%0d", r), 32'(gcnt[r] >= 4), 32'h1);

    // Back-to-back reads from requester 3
    acc = 0;
    for (int k = 0; k < 20 && acc < 4; k++) begin
      step(4'b1000, 4'h0, 16'($urandom), 32'h0);
      if (req_ready[3]) acc++;
    end
    check("tput_accepts", 32'(acc), 32'h4);
    idle(3);

    // Reset while a read is in its fetch phase
    step(4'b0001, 4'b0000, 16'h0003, 32'h0);
    do_reset();
    idle(4);
    step(4'hF, 4'h0, 16'h0, 32'h0);
    check("rr_after_rst", 32'(req_ready), 32'h3);
    idle(3);

    // Randomized traffic with a narrow address range to provoke hazards
    for (int k = 0; k < 200; k++) begin
      logic [15:0] ra;
      for (int r = 0; r < 4; r++) ra[r*4 +: 4] = 4'($urandom_range(0, 3));
      step(4'($urandom), 4'($urandom), ra, $urandom);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
